// File: rtl/if_stage.sv
`default_nettype none
// if_stage: instruction-fetch stage owning the PC, with a one-entry decode-stall hold buffer and branch redirect.
// Optional macro DELAY_SLOT_EN: execute the branch delay slot instead of squashing it.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_OP   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] op,
  output logic [15:0] op_pc,
  output logic        op_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_hold_buf;
  logic [15:0] r_hold_pc;
  logic [15:0] r_pend_tgt;
  logic        r_pend;
  logic        r_req;
  logic [15:0] r_op;
  logic [15:0] r_op_pc;
  logic        r_op_valid;

  logic [15:0] w_pc_inc;
  logic [15:0] w_next_pc;
  logic        w_done;
  logic        w_redirect;

  assign w_pc_inc   = r_pc + 16'd1;
  assign w_next_pc  = r_pend ? r_pend_tgt : w_pc_inc;
  assign w_done     = r_req & imem_ready;
  assign w_redirect = br_taken & ~stall;

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign op        = r_op;
  assign op_pc     = r_op_pc;
  assign op_valid  = r_op_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_hold_buf <= 16'h0000;
      r_hold_pc  <= 16'h0000;
      r_pend_tgt <= 16'h0000;
      r_pend     <= 1'b0;
      r_req      <= 1'b0;
      r_op       <= NOP_OP;
      r_op_pc    <= 16'h0000;
      r_op_valid <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end

        FETCH: begin
          if (w_redirect) begin
`ifdef DELAY_SLOT_EN
            if (w_done) begin
              r_op       <= imem_rdata;
              r_op_pc    <= w_pc_inc;
              r_op_valid <= 1'b1;
              r_pc       <= br_target;
              r_pend     <= 1'b0;
            end else begin
              r_op       <= NOP_OP;
              r_op_valid <= 1'b0;
              r_pend     <= 1'b1;
              r_pend_tgt <= br_target;
            end
`else
            r_op       <= NOP_OP;
            r_op_valid <= 1'b0;
            if (w_done) begin
              r_pc   <= br_target;
              r_pend <= 1'b0;
            end else begin
              // Squashed fetch still in flight: finish it in KILL, then jump.
              r_pend     <= 1'b1;
              r_pend_tgt <= br_target;
              r_state    <= KILL;
            end
`endif
          end else if (w_done) begin
            r_pc   <= w_next_pc;
            r_pend <= 1'b0;
            if (stall) begin
              r_hold_buf <= imem_rdata;
              r_hold_pc  <= w_pc_inc;
              r_req      <= 1'b0;
              r_state    <= HOLD;
            end else begin
              r_op       <= imem_rdata;
              r_op_pc    <= w_pc_inc;
              r_op_valid <= 1'b1;
            end
          end else if (!stall) begin
            r_op       <= NOP_OP;
            r_op_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (!stall) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            if (br_taken) begin
              r_pc <= br_target;
`ifdef DELAY_SLOT_EN
              r_op       <= r_hold_buf;
              r_op_pc    <= r_hold_pc;
              r_op_valid <= 1'b1;
`else
              r_op       <= NOP_OP;
              r_op_valid <= 1'b0;
`endif
            end else begin
              r_op       <= r_hold_buf;
              r_op_pc    <= r_hold_pc;
              r_op_valid <= 1'b1;
            end
          end
        end

        KILL: begin
          r_op       <= NOP_OP;
          r_op_valid <= 1'b0;
          if (imem_ready) begin
            r_pc    <= r_pend_tgt;
            r_pend  <= 1'b0;
            r_state <= FETCH;
          end
        end

        default: begin
          r_state <= BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// tb_if_stage: directed self-checking bench for if_stage; memory returns the address as data.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] op;
  logic [15:0] op_pc;
  logic        op_valid;

  int n_total = 0;
  int n_pass  = 0;

  // Observation word: {op_valid, imem_req, op, op_pc, imem_addr}
  logic [49:0] obs;
  assign obs        = {op_valid, imem_req, op, op_pc, imem_addr};
  assign imem_rdata = imem_addr;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (16'h0000),
    .NOP_OP   (16'h0800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .op         (op),
    .op_pc      (op_pc),
    .op_valid   (op_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst released just after an edge; the next step moves BOOT -> FETCH.
  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000; imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (obs !== {1'b0,1'b0,16'h0800,16'h0000,16'h0000}) $display("FAIL reset_state: obs=%h exp=%h", obs, {1'b0,1'b0,16'h0800,16'h0000,16'h0000}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b0,1'b1,16'h0800,16'h0000,16'h0000}) $display("FAIL first_req: obs=%h exp=%h", obs, {1'b0,1'b1,16'h0800,16'h0000,16'h0000}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0000,16'h0001,16'h0001}) $display("FAIL op0: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0000,16'h0001,16'h0001}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0001,16'h0002,16'h0002}) $display("FAIL op1: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0001,16'h0002,16'h0002}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0002,16'h0003,16'h0003}) $display("FAIL op2: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0002,16'h0003,16'h0003}); else n_pass++;
  endtask

  // Continues from test_reset: addr 3 in flight.
  task automatic test_wait_states();
    step(); step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0004,16'h0005,16'h0005}) $display("FAIL pre_wait: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0004,16'h0005,16'h0005}); else n_pass++;
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (obs !== {1'b0,1'b1,16'h0800,16'h0005,16'h0005}) $display("FAIL wait_bubble%0d: obs=%h exp=%h", i, obs, {1'b0,1'b1,16'h0800,16'h0005,16'h0005}); else n_pass++;
    end
    imem_ready = 1'b1;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0005,16'h0006,16'h0006}) $display("FAIL wait_done: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0005,16'h0006,16'h0006}); else n_pass++;
  endtask

  task automatic prep_addr3();
    do_reset();
    step(); step(); step(); step();
  endtask

  task automatic test_stall();
    prep_addr3();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (obs !== {1'b1,1'b0,16'h0002,16'h0003,16'h0004}) $display("FAIL stall_hold%0d: obs=%h exp=%h", i, obs, {1'b1,1'b0,16'h0002,16'h0003,16'h0004}); else n_pass++;
    end
    stall = 1'b0;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0003,16'h0004,16'h0004}) $display("FAIL stall_release: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0003,16'h0004,16'h0004}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0004,16'h0005,16'h0005}) $display("FAIL stall_next: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0004,16'h0005,16'h0005}); else n_pass++;
  endtask

  task automatic prep_addr11();
    do_reset();
    step();
    repeat (17) step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0010,16'h0011,16'h0011}) $display("FAIL pre_branch: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0010,16'h0011,16'h0011}); else n_pass++;
  endtask

  task automatic test_branch();
    logic [49:0] e;
    prep_addr11();
    br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0;
`ifdef DELAY_SLOT_EN
    e = {1'b1,1'b1,16'h0011,16'h0012,16'h0040};
`else
    e = {1'b0,1'b1,16'h0800,16'h0011,16'h0040};
`endif
    n_total++; if (obs !== e) $display("FAIL branch_slot: obs=%h exp=%h", obs, e); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0040,16'h0041,16'h0041}) $display("FAIL branch_target: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0040,16'h0041,16'h0041}); else n_pass++;
  endtask

  task automatic test_kill();
    logic [49:0] e;
    prep_addr11();
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      step();
      br_taken = 1'b0;
      n_total++; if (obs !== {1'b0,1'b1,16'h0800,16'h0011,16'h0011}) $display("FAIL kill_wait%0d: obs=%h exp=%h", i, obs, {1'b0,1'b1,16'h0800,16'h0011,16'h0011}); else n_pass++;
    end
    imem_ready = 1'b1;
    step();
`ifdef DELAY_SLOT_EN
    e = {1'b1,1'b1,16'h0011,16'h0012,16'h0040};
`else
    e = {1'b0,1'b1,16'h0800,16'h0011,16'h0040};
`endif
    n_total++; if (obs !== e) $display("FAIL kill_done: obs=%h exp=%h", obs, e); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0040,16'h0041,16'h0041}) $display("FAIL kill_target: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0040,16'h0041,16'h0041}); else n_pass++;
  endtask

  task automatic test_hold_branch();
    logic [49:0] e;
    prep_addr3();
    stall = 1'b1;
    step();
    n_total++; if (obs !== {1'b1,1'b0,16'h0002,16'h0003,16'h0004}) $display("FAIL hbr_hold: obs=%h exp=%h", obs, {1'b1,1'b0,16'h0002,16'h0003,16'h0004}); else n_pass++;
    stall = 1'b0; br_taken = 1'b1; br_target = 16'h0020;
    step();
    br_taken = 1'b0;
`ifdef DELAY_SLOT_EN
    e = {1'b1,1'b1,16'h0003,16'h0004,16'h0020};
`else
    e = {1'b0,1'b1,16'h0800,16'h0003,16'h0020};
`endif
    n_total++; if (obs !== e) $display("FAIL hbr_redirect: obs=%h exp=%h", obs, e); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0020,16'h0021,16'h0021}) $display("FAIL hbr_target: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0020,16'h0021,16'h0021}); else n_pass++;
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    step(); step();
    br_taken = 1'b1; br_target = 16'hFFFE;
    step();
    br_taken = 1'b0;
    n_total++; if (imem_addr !== 16'hFFFE) $display("FAIL wrap_redirect: addr=%h exp=%h", imem_addr, 16'hFFFE); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'hFFFE,16'hFFFF,16'hFFFF}) $display("FAIL wrap_fffe: obs=%h exp=%h", obs, {1'b1,1'b1,16'hFFFE,16'hFFFF,16'hFFFF}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'hFFFF,16'h0000,16'h0000}) $display("FAIL wrap_ffff: obs=%h exp=%h", obs, {1'b1,1'b1,16'hFFFF,16'h0000,16'h0000}); else n_pass++;
    step();
    n_total++; if (obs !== {1'b1,1'b1,16'h0000,16'h0001,16'h0001}) $display("FAIL wrap_zero: obs=%h exp=%h", obs, {1'b1,1'b1,16'h0000,16'h0001,16'h0001}); else n_pass++;
    #3;
    rst = 1'b0;
    #1;
    n_total++; if (obs !== {1'b0,1'b0,16'h0800,16'h0000,16'h0000}) $display("FAIL async_reset: obs=%h exp=%h", obs, {1'b0,1'b0,16'h0800,16'h0000,16'h0000}); else n_pass++;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000; imem_ready = 1'b1;
    test_reset();
    test_wait_states();
    test_stall();
    test_branch();
    test_kill();
    test_hold_branch();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipeline. It owns the PC, runs a request/ready handshake with instruction memory and drives the IF/ID register (op, op_pc, op_valid) consumed directly by the decoder. It supports decode stalls through a one-entry hold buffer, and redirects on taken branches/jumps reported by decode.

## Interface
Parameters:
- RESET_PC, 16'h0000, first fetch address after reset
- NOP_OP, 16'h0800, encoding injected into op for bubbles/flushes

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  decode hazard; hold IF/ID contents
- br_taken  in  1  one-cycle redirect pulse from decode; ignored while stall=1
- br_target  in  16  redirect word address, valid with br_taken
- imem_req  out  1  fetch request
- imem_addr  out  16  word address, = pc
- imem_rdata  in  16  instruction, valid when imem_ready=1
- imem_ready  in  1  fetch completes at the clk edge where imem_req & imem_ready
- op  out  16  instruction to decoder
- op_pc  out  16  address of op plus 1 (branch base)
- op_valid  out  1  op is a real instruction

## Operation
- Registers: pc[15:0], state, hold_buf[15:0], hold_pc[15:0], pend, pend_tgt[15:0].
- States: BOOT, FETCH, HOLD, KILL.
- BOOT: reset state; imem_req=0; next edge -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, both held stable until completion.
  - Complete & !stall: op<=rdata, op_pc<=pc+1, op_valid<=1, pc<=next_pc.
  - Complete & stall: hold_buf<=rdata, hold_pc<=pc+1, pc<=next_pc, -> HOLD; IF/ID unchanged.
  - Not complete & !stall: op<=NOP_OP, op_valid<=0 (bubble); op_pc unchanged.
  - Not complete & stall: IF/ID unchanged.
  - next_pc = pend ? pend_tgt : pc+1 (16-bit wrap, 16'hFFFF+1=0); pend cleared at completion.
- HOLD: imem_req=0. While stall=1 remain. When stall=0: op<=hold_buf, op_pc<=hold_pc, op_valid<=1, -> FETCH.
- Redirect (br_taken & !stall), instruction after the branch is the delay slot:
  - FETCH: delay slot is in flight. See Configuration.
  - HOLD: delay slot is hold_buf; pc<=br_target immediately (no pend). See Configuration for hold_buf.
  - KILL: br_taken does not occur (op_valid=0); ignored.
- KILL: imem_req=1 with the stale address until completion; data discarded, op=NOP_OP/op_valid=0; on completion pc<=pend_tgt, pend<=0, -> FETCH.
- Reset mid-fetch: request dropped asynchronously; memory must tolerate abandoned requests.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, op=NOP_OP, op_pc=0, op_valid=0, imem_req=0, imem_addr=RESET_PC, pend=0.
- First imem_req one cycle after rst deasserts; zero-wait memory sustains one instruction per cycle.
- Fetch-to-op latency: op updates at the completing edge (1 cycle after request for zero-wait memory).
- Stall released: buffered instruction appears on op at the next edge; the following fetch starts the same cycle.
- imem_addr/imem_req change only at clk edges (or async reset).

## Configuration
- DELAY_SLOT_EN defined: delay slot executes. In FETCH, br_taken sets pend=1, pend_tgt=br_target; in-flight fetch delivered normally, pc then goes to target. In HOLD, hold_buf delivered on the redirect edge, state -> FETCH at br_target.
- Undefined: delay slot squashed. In FETCH, at the br_taken edge op<=NOP_OP, op_valid<=0; if fetch completes that edge, data discarded and pc<=br_target, else pend_tgt<=br_target, -> KILL. In HOLD, hold_buf discarded, op<=NOP_OP, op_valid<=0, -> FETCH at br_target.

## Test plan
- Reset, zero-wait memory returning addr as data: op_valid first high 2 edges after rst release, op=0,1,2 with op_pc=1,2,3.
- imem_ready low 2 cycles at addr 5: two NOP_OP bubbles (op_valid=0), imem_addr held at 5, then op=5.
- Fetch of addr 3 completes with stall=1 for 3 cycles: op holds previous value, imem_req=0, then op=3, op_pc=4 on stall release, next fetch at 4.
- br_taken with target 16'h0040 while fetch of 0x11 in flight: with DELAY_SLOT_EN op=0x11 then 0x40; without, op=NOP_OP (op_valid=0) then 0x40.
- Same redirect with imem_ready low 3 cycles (no macro): KILL holds addr 0x11 until ready, discards it, next imem_addr=0x40.
- pc=16'hFFFF completes -> next imem_addr=16'h0000; rst asserted mid-request -> imem_req=0, op=NOP_OP immediately.
